adder_reg: RTL and testbench

- Registered n-bit two's-complement/unsigned adder used as the general-purpose adder in the datapath (PC increment, branch target, ALU add path).
- Computes Y = A + B + cin modulo 2^n, plus carry, signed-overflow and zero flags.
- All outputs are registered on one clock, giving a fixed 1-cycle latency.
- Includes a simple valid qualifier so upstream logic can mark which cycles carry a real operation.

---
 rtl/adder_reg_if.sv | 25 ++
 rtl/adder_reg.sv | 83 ++++++++
 tb/tb_adder_reg.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/adder_reg_if.sv
// Operand/result bundle for the registered adder.
// The producer of operands drives through master; the adder itself sits on slave.
interface adder_reg_if #(
  parameter int n = 32
) ();
  logic         in_valid;
  logic [n-1:0] A;
  logic [n-1:0] B;
  logic         cin;
  logic [n-1:0] Y;
  logic         cout;
  logic         ovf;
  logic         zero;
  logic         out_valid;

  modport master (
    output in_valid, A, B, cin,
    input  Y, cout, ovf, zero, out_valid
  );

  modport slave (
    input  in_valid, A, B, cin,
    output Y, cout, ovf, zero, out_valid
  );
endinterface

// File: rtl/adder_reg.sv
// Registered n-bit adder with carry, signed-overflow and zero flags, 1-cycle latency.
// The carry network is a Kogge-Stone prefix tree so depth grows as log2(n).
module adder_reg #(
  parameter int n = 32
) (
  input logic        clk,
  input logic        rst_n,
  adder_reg_if.slave bus
);
  localparam int levels = $clog2(n);

  logic [n-1:0] sum_s;
  logic         cout_s;
  logic         ovf_s;
  logic         zero_s;

  logic [n-1:0] y_r;
  logic         cout_r;
  logic         ovf_r;
  logic         zero_r;
  logic         valid_r;

  // Prefix carry tree: cin is folded into bit 0's generate, so gen_v[i] ends as carry out of bit i.
  always_comb begin
    logic [n-1:0] half_v;
    logic [n-1:0] gen_v;
    logic [n-1:0] prop_v;
    logic [n-1:0] gen_nx_v;
    logic [n-1:0] prop_nx_v;
    logic [n-1:0] carry_v;
    half_v    = bus.A ^ bus.B;
    gen_v     = bus.A & bus.B;
    gen_v[0]  = gen_v[0] | (half_v[0] & bus.cin);
    prop_v    = half_v;
    gen_nx_v  = gen_v;
    prop_nx_v = prop_v;
    for (int l = 0; l < levels; l++) begin
      gen_nx_v  = gen_v;
      prop_nx_v = prop_v;
      for (int i = (1 << l); i < n; i++) begin
        gen_nx_v[i]  = gen_v[i] | (prop_v[i] & gen_v[i - (1 << l)]);
        prop_nx_v[i] = prop_v[i] & prop_v[i - (1 << l)];
      end
      gen_v  = gen_nx_v;
      prop_v = prop_nx_v;
    end
    carry_v = {gen_v[n-2:0], bus.cin};
    sum_s   = half_v ^ carry_v;
    cout_s  = gen_v[n-1];
    ovf_s   = (bus.A[n-1] == bus.B[n-1]) && (sum_s[n-1] != bus.A[n-1]);
    zero_s  = (sum_s == {n{1'b0}});
  end

  // Result capture: flags hold through idle cycles, out_valid tracks in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_r     <= {n{1'b0}};
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      zero_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        y_r    <= sum_s;
        cout_r <= cout_s;
        ovf_r  <= ovf_s;
        zero_r <= zero_s;
      end else begin
        y_r    <= y_r;
        cout_r <= cout_r;
        ovf_r  <= ovf_r;
        zero_r <= zero_r;
      end
    end
  end

  assign bus.Y         = y_r;
  assign bus.cout      = cout_r;
  assign bus.ovf       = ovf_r;
  assign bus.zero      = zero_r;
  assign bus.out_valid = valid_r;
endmodule

// File: tb/tb_adder_reg.sv
// Bench for adder_reg: n=32 directed vectors plus an exhaustive n=4 sweep,
// both checked every cycle against an integer-arithmetic reference.
module tb_adder_reg;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  bit   checking;

  typedef struct packed {
    logic [63:0] y;
    logic        co;
    logic        ov;
    logic        z;
  } res_t;

  adder_reg_if #(.n(32)) bus32 ();
  adder_reg_if #(.n(4))  bus4 ();

  adder_reg #(.n(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  adder_reg #(.n(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer sum, signed range test for overflow.
  function automatic res_t ref_add(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic c);
    res_t        r;
    logic [63:0] s;
    longint      sa;
    longint      sb;
    longint      ss;
    longint      lim;
    s    = a + b + {63'd0, c};
    r.y  = s & ((64'd1 << w) - 64'd1);
    r.co = s[w];
    lim  = longint'(64'd1 << (w - 1));
    sa   = a[w-1] ? longint'(a) - 2 * lim : longint'(a);
    sb   = b[w-1] ? longint'(b) - 2 * lim : longint'(b);
    ss   = sa + sb + longint'({63'd0, c});
    r.ov = (ss >= lim) || (ss < -lim);
    r.z  = (r.y == 64'd0);
    return r;
  endfunction

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic void check1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endfunction

  res_t m32;
  res_t m4;
  res_t e32;
  res_t e4;
  logic e32_v;
  logic e4_v;

  assign m32 = ref_add(32, {32'd0, bus32.A}, {32'd0, bus32.B}, bus32.cin);
  assign m4  = ref_add(4, {60'd0, bus4.A}, {60'd0, bus4.B}, bus4.cin);

  // Expected output state: captured on valid edges, held otherwise.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e32   <= '0;
      e4    <= '0;
      e32_v <= 1'b0;
      e4_v  <= 1'b0;
    end else begin
      e32_v <= bus32.in_valid;
      e4_v  <= bus4.in_valid;
      if (bus32.in_valid) e32 <= m32;
      if (bus4.in_valid)  e4  <= m4;
    end
  end

  // Per-cycle compare of both instances against the reference state.
  always @(negedge clk) begin
    if (checking) begin
      check("m32.Y", {32'd0, bus32.Y}, e32.y);
      check1("m32.cout", bus32.cout, e32.co);
      check1("m32.ovf", bus32.ovf, e32.ov);
      check1("m32.zero", bus32.zero, e32.z);
      check1("m32.out_valid", bus32.out_valid, e32_v);
      check("m4.Y", {60'd0, bus4.Y}, e4.y);
      check1("m4.cout", bus4.cout, e4.co);
      check1("m4.ovf", bus4.ovf, e4.ov);
      check1("m4.zero", bus4.zero, e4.z);
      check1("m4.out_valid", bus4.out_valid, e4_v);
    end
  end

  task automatic lit(input string nm, input logic [31:0] ey, input logic ec, input logic eo,
                     input logic ez, input logic ev);
    check({nm, ".Y"}, {32'd0, bus32.Y}, {32'd0, ey});
    check1({nm, ".cout"}, bus32.cout, ec);
    check1({nm, ".ovf"}, bus32.ovf, eo);
    check1({nm, ".zero"}, bus32.zero, ez);
    check1({nm, ".out_valid"}, bus32.out_valid, ev);
  endtask

  task automatic vec(input string nm, input logic [31:0] a, input logic [31:0] b, input logic c,
                     input logic [31:0] ey, input logic ec, input logic eo, input logic ez);
    bus32.in_valid = 1'b1;
    bus32.A        = a;
    bus32.B        = b;
    bus32.cin      = c;
    @(negedge clk);
    lit(nm, ey, ec, eo, ez, 1'b1);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    checking = 1'b0;
    rst_n    = 1'b0;
    bus32.in_valid = 1'b0; bus32.A = 32'd0; bus32.B = 32'd0; bus32.cin = 1'b0;
    bus4.in_valid  = 1'b0; bus4.A  = 4'd0;  bus4.B  = 4'd0;  bus4.cin  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    checking = 1'b1;
    @(negedge clk);
    lit("after_reset", 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);

    vec("basic",    32'h0000_0003, 32'h0000_0004, 1'b0, 32'h0000_0007, 1'b0, 1'b0, 1'b0);
    vec("uwrap",    32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    vec("uwrap_ci", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    vec("sovf_pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    vec("sovf_neg", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
    vec("cin_only", 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    vec("cancel",   32'h0000_0005, 32'hFFFF_FFFB, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    vec("carry_mid",32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);

    vec("stream1", 32'd1, 32'd1, 1'b0, 32'd2, 1'b0, 1'b0, 1'b0);
    vec("stream2", 32'd2, 32'd2, 1'b0, 32'd4, 1'b0, 1'b0, 1'b0);
    vec("stream3", 32'd3, 32'd3, 1'b0, 32'd6, 1'b0, 1'b0, 1'b0);
    bus32.in_valid = 1'b0;
    bus32.A        = 32'h1234_5678;
    bus32.B        = 32'h0000_0009;
    @(negedge clk);
    lit("idle_hold", 32'd6, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle with an operation presented on the inputs.
    vec("pre_reset", 32'd2, 32'd3, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0);
    bus32.A = 32'd10;
    bus32.B = 32'd10;
    #2;
    rst_n = 1'b0;
    #1;
    lit("reset_async", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    lit("reset_held", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus32.in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    lit("reset_release", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          bus4.in_valid = 1'b1;
          bus4.A        = 4'(a);
          bus4.B        = 4'(b);
          bus4.cin      = 1'(c);
          @(negedge clk);
        end
      end
    end
    bus4.in_valid = 1'b0;
    bus4.A        = 4'd3;
    @(negedge clk);
    check("m4.last_hold", {60'd0, bus4.Y}, 64'd15);
    check1("m4.last_cout", bus4.cout, 1'b1);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
